fifo_rd_packer: RTL and testbench

- Read-side consumer of the async FIFO, in the rclk domain.
- Drains bytes through the FIFO's ren/rdata/valid/empty read port and packs LANES bytes into one word.
- Presents each word on a valid/ready stream with a per-lane keep mask.
- Partial words are emitted on an explicit flush or after an idle timeout, so short bursts are not stranded.

---
 rtl/fifo_rd_packer.sv | 134 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side byte packer for the async FIFO (rclk domain): drains bytes one at a
// time and presents LANES-byte words with a keep mask on a valid/ready stream.
module fifo_rd_packer #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     rclk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    output logic                     fifo_ren,
    input  logic [WIDTH-1:0]         fifo_rdata,
    input  logic                     fifo_valid,
    input  logic                     flush,
    output logic [WIDTH*LANES-1:0]   out_data,
    output logic [LANES-1:0]         out_keep,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_unexp
);

    localparam int CW = $clog2(LANES + 1);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LW = $clog2(LANES);

    logic [LANES-1:0][WIDTH-1:0] r_acc;
    logic [CW-1:0]               r_cnt;
    logic                        r_pend;
    logic                        r_flush_pend;
    logic [IW-1:0]               r_idle;
    logic                        r_err;
    logic [WIDTH*LANES-1:0]      r_out_data;
    logic [LANES-1:0]            r_out_keep;
    logic                        r_out_valid;

    logic [CW:0]                 w_inflight;
    logic                        w_ren;
    logic                        w_cap;
    logic                        w_unexp;
    logic                        w_full;
    logic                        w_tmo;
    logic                        w_partial;
    logic                        w_slot;
    logic                        w_emit;
    logic [LANES-1:0]            w_keep;

    // Bytes already held plus the one in flight must leave room in the word.
    assign w_inflight = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
    assign w_ren      = !rst && !fifo_empty && !r_flush_pend &&
                        (w_inflight < (CW+1)'(LANES));
    assign w_cap      = fifo_valid && r_pend;
    assign w_unexp    = fifo_valid && !r_pend;
    assign w_full     = (r_cnt == CW'(LANES));
    assign w_tmo      = (TIMEOUT > 0) && (r_idle == IW'(TIMEOUT));
    assign w_partial  = (r_cnt != '0) && !r_pend && (r_flush_pend || w_tmo);
    assign w_slot     = !r_out_valid || out_ready;
    assign w_emit     = (w_full || w_partial) && w_slot;

    always_comb begin
        w_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            w_keep[i] = (CW'(i) < r_cnt);
        end
    end

    // NOTE: the accumulator sits on the async reset so a reset mid-word leaves
    // no stale bytes in the unfilled lanes of the next emitted word.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_ren;
            if (w_emit) begin
                // NOTE: later non-blocking writes win, so lane 0 can be refilled
                // in the same cycle the rest of the accumulator is cleared.
                r_acc <= '0;
                if (w_cap) begin
                    r_acc[0] <= fifo_rdata;
                end
                r_cnt <= w_cap ? CW'(1) : '0;
            end else if (w_cap) begin
                r_acc[r_cnt[LW-1:0]] <= fifo_rdata;
                r_cnt                <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_idle       <= '0;
            r_flush_pend <= 1'b0;
            r_err        <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_emit || w_cap) begin
                r_idle <= '0;
            end else if ((r_cnt != '0) && !fifo_valid && (r_idle != IW'(TIMEOUT))) begin
                r_idle <= r_idle + IW'(1);
            end

            // A flush with nothing held or in flight simply retires.
            if (w_emit && r_flush_pend) begin
                r_flush_pend <= 1'b0;
            end else if (r_flush_pend && (r_cnt == '0) && !r_pend) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end

            if (w_unexp) begin
                r_err <= 1'b1;
            end

            if (w_emit) begin
                r_out_data  <= r_acc;
                r_out_keep  <= w_keep;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign fifo_ren  = w_ren;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_valid = r_out_valid;
    assign err_unexp = r_err;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed and randomized bench for fifo_rd_packer: a FIFO model feeds bytes,
// and a chunking model of the byte stream predicts every accepted word.
module tb_fifo_rd_packer;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int TO    = 16;

    logic        rclk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [7:0]  fifo_rdata;
    logic        fifo_valid;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic        err_unexp;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } word_t;

    word_t       exp_q[$];
    logic [7:0]  fifo_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          ren_total   = 0;
    bit          force_v     = 1'b0;
    bit          prev_stall  = 1'b0;
    logic [31:0] held_d;
    logic [3:0]  held_k;

    fifo_rd_packer #(.WIDTH(WIDTH), .LANES(LANES), .TIMEOUT(TO)) dut (
        .rclk       (rclk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_rdata (fifo_rdata),
        .fifo_valid (fifo_valid),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_unexp  (err_unexp)
    );

    always #5 rclk = ~rclk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Reference: the byte stream, cut into LANES-byte words, last one partial.
    task automatic expect_bytes(input logic [7:0] b[$]);
        word_t w;
        int    n = 0;
        w.data = '0;
        w.keep = '0;
        foreach (b[i]) begin
            w.data[8*n +: 8] = b[i];
            w.keep[n]        = 1'b1;
            n++;
            if (n == LANES) begin
                exp_q.push_back(w);
                w.data = '0;
                w.keep = '0;
                n      = 0;
            end
        end
        if (n > 0) exp_q.push_back(w);
    endtask

    task automatic load(input logic [7:0] b[$]);
        foreach (b[i]) fifo_q.push_back(b[i]);
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // One clock: called at a negedge, returns at the next negedge.
    task automatic step();
        logic  ren_s;
        word_t w;
        ren_s = fifo_ren;
        if (ren_s) ren_total++;
        if (prev_stall) begin
            check("hold_data", out_data, held_d);
            check("hold_keep", out_keep, held_k);
            check("hold_valid", out_valid, 1);
        end
        prev_stall = out_valid && !out_ready;
        held_d     = out_data;
        held_k     = out_keep;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", exp_q.size(), 1);
            end else begin
                w = exp_q.pop_front();
                check("word_data", out_data, w.data);
                check("word_keep", out_keep, w.keep);
            end
        end
        @(posedge rclk);
        #1;
        if (ren_s) begin
            if (fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
            else check("ren_on_empty", fifo_q.size(), 1);
            fifo_valid = 1'b1;
        end else if (force_v) begin
            fifo_rdata = 8'hEE;
            fifo_valid = 1'b1;
            force_v    = 1'b0;
        end else begin
            fifo_valid = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
        flush      = 1'b0;
        @(negedge rclk);
    endtask

    task automatic drain(input string tag, input int budget, input bit rand_ready);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        out_ready = 1'b1;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_fifo_drained(input string tag, input bit rand_ready);
        int n = 0;
        while (!(fifo_q.size() == 0 && !fifo_valid) && n < 200) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        check(tag, fifo_q.size() + int'(fifo_valid), 0);
    endtask

    initial begin
        logic [7:0] bs[$];
        int         n;
        int         rens;
        int         len;

        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_valid = 1'b0;
        fifo_rdata = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        fifo_empty = 1'b0;
        #1;
        check("rst_ren", fifo_ren, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_keep", out_keep, 0);
        check("rst_err", err_unexp, 0);
        fifo_empty = 1'b1;
        @(negedge rclk);
        rst = 1'b0;
        step();
        check("idle_valid", out_valid, 0);

        // Two full words 0x44332211, 0x88776655.
        bs.delete();
        for (int i = 1; i <= 8; i++) bs.push_back(8'(i * 17));
        load(bs);
        expect_bytes(bs);
        ren_total = 0;
        drain("tA_drain", 60, 1'b0);
        check("tA_ren_count", ren_total, 8);
        check("tA_ren_idle", fifo_ren, 0);

        // Idle timeout emits a 3-byte partial word.
        bs.delete();
        bs.push_back(8'hA1); bs.push_back(8'hA2); bs.push_back(8'hA3);
        load(bs);
        expect_bytes(bs);
        n = 0;
        while (!(fifo_q.size() == 0 && fifo_valid) && n < 20) begin
            step();
            n++;
        end
        step();
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("tB_latency", n, TO + 1);
        drain("tB_drain", 10, 1'b0);

        // Flush in the cycle of the second read: that byte still lands.
        bs.delete();
        bs.push_back(8'hB1); bs.push_back(8'hB2);
        load(bs);
        expect_bytes(bs);
        bs.delete();
        bs.push_back(8'hC1); bs.push_back(8'hC2); bs.push_back(8'hC3); bs.push_back(8'hC4);
        load(bs);
        expect_bytes(bs);
        rens = 0;
        n    = 0;
        while (rens < 2 && n < 10) begin
            if (fifo_ren) begin
                rens++;
                if (rens == 2) flush = 1'b1;
            end
            step();
            n++;
        end
        check("tC_flush_issued", rens, 2);
        n = 0;
        while (!out_valid && n < 10) begin
            check("tC_no_ren", fifo_ren, 0);
            step();
            n++;
        end
        check("tC_emit", out_valid, 1);
        check("tC_keep", out_keep, 4'b0011);
        drain("tC_drain", 40, 1'b0);

        // Backpressure with 12 bytes queued.
        out_ready = 1'b0;
        bs.delete();
        for (int i = 0; i < 12; i++) bs.push_back(8'($urandom));
        load(bs);
        expect_bytes(bs);
        repeat (30) step();
        check("tD_ren_blocked", fifo_ren, 0);
        check("tD_fifo_left", fifo_q.size(), 4);
        check("tD_valid", out_valid, 1);
        check("tD_keep", out_keep, 4'b1111);
        check("tD_first_word", out_data, exp_q[0].data);
        out_ready = 1'b1;
        drain("tD_drain", 80, 1'b0);

        // Random bursts closed by flush, random downstream stalls.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 12);
            bs.delete();
            for (int i = 0; i < len; i++) bs.push_back(8'($urandom));
            load(bs);
            expect_bytes(bs);
            wait_fifo_drained("tE_fifo_drain", 1'b1);
            flush = 1'b1;
            step();
            drain("tE_drain", 300, 1'b1);
        end

        // Unexpected fifo_valid mid-word: flagged, byte dropped.
        check("tF_err_before", err_unexp, 0);
        bs.delete();
        bs.push_back(8'($urandom)); bs.push_back(8'($urandom));
        load(bs);
        wait_fifo_drained("tF_fifo_drain", 1'b0);
        force_v = 1'b1;
        step();
        step();
        check("tF_err_set", err_unexp, 1);
        check("tF_no_emit", out_valid, 0);
        bs.push_back(8'($urandom)); bs.push_back(8'($urandom));
        load(bs[2:3]);
        expect_bytes(bs);
        drain("tF_drain", 40, 1'b0);
        repeat (3) step();
        check("tF_err_sticky", err_unexp, 1);

        // Asynchronous reset with a held word and two bytes accumulated.
        out_ready = 1'b0;
        bs.delete();
        for (int i = 0; i < 6; i++) bs.push_back(8'($urandom));
        load(bs);
        expect_bytes(bs);
        repeat (20) step();
        check("tG_pre_valid", out_valid, 1);
        check("tG_pre_keep", out_keep, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        check("tG_async_valid", out_valid, 0);
        check("tG_async_data", out_data, 0);
        check("tG_async_keep", out_keep, 0);
        check("tG_async_err", err_unexp, 0);
        check("tG_async_ren", fifo_ren, 0);
        exp_q.delete();
        fifo_q.delete();
        prev_stall = 1'b0;
        fifo_valid = 1'b0;
        fifo_empty = 1'b1;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rst       = 1'b0;
        out_ready = 1'b1;
        bs.delete();
        for (int i = 0; i < 4; i++) bs.push_back(8'($urandom));
        load(bs);
        expect_bytes(bs);
        drain("tG_drain", 40, 1'b0);
        repeat (3) step();
        check("tG_quiet", out_valid, 0);
        check("tG_err_clear", err_unexp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
